mem_arbiter: RTL and testbench

Shares the single data port of the 32K×16 main RAM between the CPU data path and the video scan-out fetcher. Grants one access per cycle: CPU priority by default, with a bounded-wait guarantee for video so the display never starves. Issues registered address, write data and write enable to the RAM, tracks in-flight reads, and routes returned data to the correct requester. Sits between CPU/video and RAM in the Computer top level, replacing the RAM's second (video) port.

---
 rtl/hack_mem_pkg.sv | 25 ++
 rtl/arb_resp_pipe.sv | 33 +++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared widths, defaults and the response owner tag for the main-RAM arbiter.
package hack_mem_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SCREEN_W = 13;

  localparam logic [ADDR_W-1:0] SCREEN_BASE_DEF = 15'h4000;

  // Who owns the read data returning from the RAM in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } own_t;

  // Screen word offset to absolute RAM word address.
  function automatic logic [ADDR_W-1:0] vid_to_mem(
    input logic [ADDR_W-1:0]   base,
    input logic [SCREEN_W-1:0] offset
  );
    return base + {{(ADDR_W-SCREEN_W){1'b0}}, offset};
  endfunction

endpackage

// File: rtl/arb_resp_pipe.sv
// Two-stage owner-tag pipeline: follows each issued access through the RAM
// latency and flags which requester the returning data belongs to.
module arb_resp_pipe
  import hack_mem_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  own_t issue_tag,
  output logic cpu_rvalid,
  output logic vid_rvalid
);

  own_t stage1;
  own_t stage2;

  // Stage 1 aligns with the RAM address, stage 2 with the returned data.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage1 <= OWN_NONE;
      stage2 <= OWN_NONE;
    end else begin
      stage1 <= issue_tag;
      stage2 <= stage1;
    end
  end

  // Decode the data-aligned tag into per-requester valid strobes.
  always_comb begin
    cpu_rvalid = (stage2 == OWN_CPU);
    vid_rvalid = (stage2 == OWN_VID);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-RAM arbiter: CPU has priority, video gets a bounded wait.
// Issues registered address/data/enable and routes read data back by tag.
module mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SCREEN_BASE  = SCREEN_BASE_DEF,
  parameter int unsigned       VID_MAX_WAIT = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  input  logic                vid_req,
  input  logic [SCREEN_W-1:0] vid_addr,
  output logic                vid_gnt,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_rvalid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] MAX_WAIT = 4'(VID_MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       vid_forced;
  own_t       issue_tag;

  // Grant decision: CPU first unless video has waited its full allowance.
  always_comb begin
    vid_forced = vid_req && (wait_cnt == MAX_WAIT);
    cpu_gnt    = 1'b0;
    vid_gnt    = 1'b0;
    if (!reset) begin
      if (cpu_req && !vid_forced) begin
        cpu_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end
    end
  end

  // Count cycles a pending video request is refused; clear on grant or drop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!vid_req || vid_gnt) begin
      wait_cnt <= '0;
    end else if (cpu_gnt) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Register the winning access onto the RAM port; idle cycles hold the address.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= cpu_gnt && cpu_we;
      if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vid_gnt) begin
        mem_addr <= vid_to_mem(SCREEN_BASE, vid_addr);
      end
    end
  end

  // Tag each issued read with its owner; writes and idle cycles carry no owner.
  always_comb begin
    issue_tag = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      issue_tag = OWN_CPU;
    end else if (vid_gnt) begin
      issue_tag = OWN_VID;
    end
  end

  arb_resp_pipe u_resp_pipe (
    .clock      (clock),
    .reset      (reset),
    .issue_tag  (issue_tag),
    .cpu_rvalid (cpu_rvalid),
    .vid_rvalid (vid_rvalid)
  );

  // Read data is shared; only the rvalid strobes say whose it is.
  always_comb begin
    cpu_rdata = mem_rdata;
    vid_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_gnt;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ram [0:32767];

  mem_arbiter #(.SCREEN_BASE(15'h4000), .VID_MAX_WAIT(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM, read data one cycle after address.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [9:0] exp_vg;
  logic [9:0] exp_vrv;
  logic [9:0] exp_crv;
  logic [6:0] seq_vreq;
  logic [6:0] seq_vg;

  initial begin
    for (int unsigned a = 0; a < 32768; a++) ram[a] = '0;
    ram[15'h4000] = 16'h1234;
    ram[15'h5FFF] = 16'hABCD;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;

    // Reset state, with requests present to confirm grants are suppressed.
    tick();
    cpu_req = 1'b1; vid_req = 1'b1;
    tick();
    check("rst_cpu_gnt", {31'b0, cpu_gnt}, 0);
    check("rst_vid_gnt", {31'b0, vid_gnt}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_addr", {17'b0, mem_addr}, 0);
    check("rst_mem_wdata", {16'b0, mem_wdata}, 0);
    check("rst_rvalid", {30'b0, cpu_rvalid, vid_rvalid}, 0);
    cpu_req = 1'b0; vid_req = 1'b0; reset = 1'b0;
    tick();

    // CPU write then back-to-back read of the same address.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 16'hBEEF;
    #1;
    check("wr_cpu_gnt", {31'b0, cpu_gnt}, 1);
    check("wr_vid_gnt", {31'b0, vid_gnt}, 0);
    tick();
    check("wr_mem_addr", {17'b0, mem_addr}, 32'h10);
    check("wr_mem_wdata", {16'b0, mem_wdata}, 32'hBEEF);
    check("wr_mem_we", {31'b0, mem_we}, 1);
    cpu_we = 1'b0; cpu_wdata = 16'h0000;
    #1;
    check("rd_cpu_gnt", {31'b0, cpu_gnt}, 1);
    tick();
    cpu_req = 1'b0;
    check("rd_mem_we", {31'b0, mem_we}, 0);
    check("rd_mem_addr", {17'b0, mem_addr}, 32'h10);
    check("wr_no_rvalid", {30'b0, cpu_rvalid, vid_rvalid}, 0);
    tick();
    check("rd_cpu_rvalid", {31'b0, cpu_rvalid}, 1);
    check("rd_vid_rvalid", {31'b0, vid_rvalid}, 0);
    check("rd_cpu_rdata", {16'b0, cpu_rdata}, 32'hBEEF);
    tick();
    check("rd_rvalid_once", {30'b0, cpu_rvalid, vid_rvalid}, 0);

    // Video alone at both ends of the screen.
    vid_req = 1'b1; vid_addr = 13'd0;
    #1;
    check("v0_vid_gnt", {31'b0, vid_gnt}, 1);
    check("v0_cpu_gnt", {31'b0, cpu_gnt}, 0);
    tick();
    check("v0_mem_addr", {17'b0, mem_addr}, 32'h4000);
    check("v0_mem_we", {31'b0, mem_we}, 0);
    vid_addr = 13'd8191;
    #1;
    check("v1_vid_gnt", {31'b0, vid_gnt}, 1);
    tick();
    vid_req = 1'b0;
    check("v1_mem_addr", {17'b0, mem_addr}, 32'h5FFF);
    check("v1_mem_we", {31'b0, mem_we}, 0);
    check("v0_vid_rvalid", {31'b0, vid_rvalid}, 1);
    check("v0_vid_rdata", {16'b0, vid_rdata}, 32'h1234);
    check("v0_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    tick();
    check("v1_vid_rvalid", {31'b0, vid_rvalid}, 1);
    check("v1_vid_rdata", {16'b0, vid_rdata}, 32'hABCD);
    tick();
    check("v_rvalid_end", {30'b0, cpu_rvalid, vid_rvalid}, 0);

    // Both requesting continuously: CPU,CPU,CPU,VID repeating.
    exp_vg  = 10'b00_1000_1000;
    exp_crv = 10'b01_1101_1100;
    exp_vrv = 10'b10_0010_0000;
    for (int i = 0; i < 10; i++) begin
      cpu_req = (i < 8); vid_req = (i < 8);
      cpu_we = 1'b0; cpu_addr = 15'h0010; vid_addr = 13'd5;
      #1;
      if (i < 8) begin
        check($sformatf("both_vid_gnt_%0d", i), {31'b0, vid_gnt}, {31'b0, exp_vg[i]});
        check($sformatf("both_cpu_gnt_%0d", i), {31'b0, cpu_gnt}, {31'b0, ~exp_vg[i]});
      end
      check($sformatf("both_cpu_rvalid_%0d", i), {31'b0, cpu_rvalid}, {31'b0, exp_crv[i]});
      check($sformatf("both_vid_rvalid_%0d", i), {31'b0, vid_rvalid}, {31'b0, exp_vrv[i]});
      if (exp_crv[i]) check($sformatf("both_cpu_rdata_%0d", i), {16'b0, cpu_rdata}, 32'hBEEF);
      tick();
    end

    // Video drops after two refusals, then must be refused three more times.
    seq_vreq = 7'b111_1011;
    seq_vg   = 7'b100_0000;
    for (int i = 0; i < 7; i++) begin
      cpu_req = 1'b1; vid_req = seq_vreq[i];
      #1;
      check($sformatf("drop_vid_gnt_%0d", i), {31'b0, vid_gnt}, {31'b0, seq_vg[i]});
      check($sformatf("drop_cpu_gnt_%0d", i), {31'b0, cpu_gnt}, {31'b0, ~seq_vg[i]});
      if (i == 3) check("drop_wait_cnt", {28'b0, dut.wait_cnt}, 0);
      tick();
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    tick();
    tick();

    // Reset one cycle after a CPU read grant drops the read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    #1;
    check("rr_cpu_gnt", {31'b0, cpu_gnt}, 1);
    tick();
    reset = 1'b1; vid_req = 1'b1;
    #1;
    check("rr_gnt_in_reset", {30'b0, cpu_gnt, vid_gnt}, 0);
    tick();
    reset = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    #1;
    check("rr_rvalid_0", {30'b0, cpu_rvalid, vid_rvalid}, 0);
    check("rr_mem_addr", {17'b0, mem_addr}, 0);
    check("rr_mem_wdata", {16'b0, mem_wdata}, 0);
    check("rr_mem_we", {31'b0, mem_we}, 0);
    check("rr_wait_cnt", {28'b0, dut.wait_cnt}, 0);
    tick();
    check("rr_rvalid_1", {30'b0, cpu_rvalid, vid_rvalid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
